// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display bundle for bcd_display_ctrl.
//   Start, Value      : conversion request and binary operand (master -> slave)
//   Busy, Done        : conversion status (slave -> master)
//   BCD               : latched result, [11:8] hundreds, [7:4] tens, [3:0] ones
//   HEX2, HEX1, HEX0  : active-high seven-segment drive, bit 0 = a ... bit 6 = g
interface bcd_display_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Value;
    logic             Busy;
    logic             Done;
    logic [11:0]      BCD;
    logic [6:0]       HEX2;
    logic [6:0]       HEX1;
    logic [6:0]       HEX0;

    modport master (
        output Start, Value,
        input  Busy, Done, BCD, HEX2, HEX1, HEX0
    );

    modport slave (
        input  Start, Value,
        output Busy, Done, BCD, HEX2, HEX1, HEX0
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving three leading-zero-blanked seven-segment digits.
//   Clock  : rising-edge clock
//   Resetn : asynchronous reset, active-low
//   bus    : slave side of bcd_display_ctrl_if (Start/Value in; Busy/Done,
//            BCD and HEX2..HEX0 out)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for Start; operand captured on the accepting edge
//   SHIFT | one adjust+shift step per edge, Busy high
//   DONE  | result just latched, Done high for one cycle
module bcd_display_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                Clock,
    input  logic                Resetn,
    bcd_display_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [11:0]      scratch_q, scratch_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [11:0]      adj;
    logic [11:0]      shifted;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
        end
    end

    // Scratch digits stay <= 9 for WIDTH <= 9, so the adjusted top bit is
    // always zero and is safely dropped by the shift.
    always_comb begin
        adj     = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        shifted = {adj[10:0], shreg_q[WIDTH-1]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d   = SHIFT;
                    shreg_d   = bus.Value;
                    scratch_d = '0;
                    cnt_d     = 4'(WIDTH);
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    bcd_d   = shifted;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.Busy = (state_q == SHIFT);
        bus.Done = (state_q == DONE);
        bus.BCD  = bcd_q;
        bus.HEX0 = seg7(bcd_q[3:0]);
        bus.HEX1 = seg7(bcd_q[7:4]);
        bus.HEX2 = seg7(bcd_q[11:8]);
        if (bcd_q[11:8] == 4'd0) begin
            bus.HEX2 = 7'h00;
            if (bcd_q[7:4] == 4'd0) begin
                bus.HEX1 = 7'h00;
            end
        end
    end
endmodule

// File: tb/tb_bcd_display_ctrl.sv
module tb_bcd_display_ctrl;
    localparam int W = 8;

    logic Clock = 1'b0;
    logic Resetn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_q[$];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    bcd_display_ctrl_if #(.WIDTH(W)) bus ();
    bcd_display_ctrl #(.WIDTH(W)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));

    function automatic logic [6:0] seg_model(input int d);
        logic [6:0] t[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    function automatic logic [11:0] bcd_model(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        int v;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected_done observed=Done expected=no_result_pending", tag);
        end else begin
            v = exp_q.pop_front();
            chk({tag, "_bcd"}, bus.BCD, bcd_model(v));
            chk({tag, "_hex0"}, bus.HEX0, seg_model(v % 10));
            chk({tag, "_hex1"}, bus.HEX1, (v < 10) ? 7'h00 : seg_model((v / 10) % 10));
            chk({tag, "_hex2"}, bus.HEX2, (v < 100) ? 7'h00 : seg_model(v / 100));
        end
    endtask

    // Inputs driven at a falling edge; returns at the falling edge after the
    // accepting rising edge with Start already dropped.
    task automatic start_conv(input int v, input bit push);
        bus.Start = 1'b1;
        bus.Value = W'(v);
        if (push) exp_q.push_back(v);
        @(posedge Clock);
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int busy_n = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.Done) begin
                seen = 1;
                chk({tag, "_busy_with_done"}, bus.Busy, 0);
                check_result(tag);
            end else begin
                if (bus.Busy) busy_n++;
                @(negedge Clock);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        @(negedge Clock);
        chk({tag, "_done_width"}, bus.Done, 0);
        chk({tag, "_idle_busy"}, bus.Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int last;
        Resetn    = 1'b0;
        bus.Start = 1'b1;
        bus.Value = W'(85);
        #1;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_bcd", bus.BCD, 12'h000);
        chk("rst_hex2", bus.HEX2, 7'h00);
        chk("rst_hex1", bus.HEX1, 7'h00);
        chk("rst_hex0", bus.HEX0, 7'h3F);
        repeat (2) @(negedge Clock);
        chk("rst_hold_busy", bus.Busy, 0);

        Resetn = 1'b1;
        start_conv(3, 1);
        chk("rel_accept_busy", bus.Busy, 1);
        wait_done("rel", W);

        start_conv(255, 1);
        wait_done("v255", W);
        start_conv(9, 1);
        wait_done("v9", W);
        start_conv(10, 1);
        wait_done("v10", W);
        start_conv(100, 1);
        wait_done("v100", W);

        // Start re-asserted with a new operand while shifting must be ignored.
        start_conv(200, 1);
        repeat (3) begin
            bus.Start = 1'b1;
            bus.Value = W'(7);
            chk("ign_hold_bcd", bus.BCD, bcd_model(100));
            @(negedge Clock);
        end
        bus.Start = 1'b0;
        wait_done("ign200", W - 3);
        repeat (3) begin
            @(negedge Clock);
            chk("ign_no_restart", bus.Busy, 0);
            chk("ign_no_done", bus.Done, 0);
        end

        // Reset three cycles into a conversion aborts it.
        start_conv(123, 0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        chk("abort_bcd", bus.BCD, 12'h000);
        chk("abort_busy", bus.Busy, 0);
        chk("abort_hex0", bus.HEX0, 7'h3F);
        repeat (2) begin
            @(negedge Clock);
            chk("abort_no_done", bus.Done, 0);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        chk("abort_idle_done", bus.Done, 0);
        start_conv(42, 1);
        wait_done("v42", W);

        // Start held high: back-to-back conversions, operand stepped per accept.
        n = 0;
        last = -1;
        bus.Start = 1'b1;
        bus.Value = W'(0);
        exp_q.push_back(0);
        for (int i = 0; i < 200 && n < 5; i++) begin
            @(negedge Clock);
            if (bus.Done) begin
                check_result("held");
                chk("held_busy_with_done", bus.Busy, 0);
                if (last >= 0) chk("held_spacing", cyc - last, W + 2);
                last = cyc;
                n++;
                if (n < 5) begin
                    bus.Value = W'(n);
                    exp_q.push_back(n);
                end else begin
                    bus.Start = 1'b0;
                end
            end
        end
        chk("held_count", n, 5);
        @(negedge Clock);
        chk("held_done_width", bus.Done, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
